// File: rtl/short_preamble_inserter.sv
// Prefixes each AXI-Stream packet with a programmable repeating preamble,
// then passes the payload through and appends an optional run of zero samples.
module short_preamble_inserter #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned PERIOD          = 16,
    parameter int unsigned NUM_REPEATS     = 10,
    parameter int unsigned GAP_LEN         = 0,
    parameter int unsigned SR_PATTERN_BASE = 128,
    parameter int unsigned SR_CTRL         = 127
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tuser,
    output logic             o_tvalid,
    input  logic             o_tready
);

    localparam int unsigned IdxW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        rep_q, rep_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0]  pattern_q [PERIOD];
    logic [WIDTH-1:0]  pattern_d [PERIOD];
    logic              ctrl_en_q, ctrl_en_d;
    logic [7:0]        ctrl_rep_q, ctrl_rep_d;
    logic [15:0]       ctrl_gap_q, ctrl_gap_d;
    logic [7:0]        num_rep_q, num_rep_d;
    logic [15:0]       gap_len_q, gap_len_d;

    logic              valid_c, ready_c, last_c, user_c;
    logic [WIDTH-1:0]  data_c;
    logic              unused_set_bits;

    assign unused_set_bits = ^set_data[7:1];

    always_comb begin
        pattern_d  = pattern_q;
        ctrl_en_d  = ctrl_en_q;
        ctrl_rep_d = ctrl_rep_q;
        ctrl_gap_d = ctrl_gap_q;
        for (int k = 0; k < PERIOD; k++) begin
            if (set_stb && set_addr == 8'(SR_PATTERN_BASE + k)) begin
                pattern_d[k] = set_data[WIDTH-1:0];
            end
        end
        if (set_stb && set_addr == 8'(SR_CTRL)) begin
            ctrl_en_d  = set_data[0];
            ctrl_rep_d = set_data[15:8];
            ctrl_gap_d = set_data[31:16];
        end
    end

    // Packet parameters are snapshotted on leaving idle so mid-packet control
    // writes only take effect on the following packet.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gap_cnt_d = gap_cnt_q;
        num_rep_d = num_rep_q;
        gap_len_d = gap_len_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_tvalid) begin
                    num_rep_d = ctrl_rep_q;
                    gap_len_d = ctrl_gap_q;
                    idx_d     = '0;
                    rep_d     = '0;
                    gap_cnt_d = '0;
                    state_d   = (ctrl_en_q && ctrl_rep_q != 8'd0) ? S_PREAMBLE : S_PAYLOAD;
                end
            end
            S_PREAMBLE: begin
                if (o_tready) begin
                    if (idx_q == IdxW'(PERIOD - 1)) begin
                        idx_d = '0;
                        if (rep_q == num_rep_q - 8'd1) begin
                            rep_d   = '0;
                            state_d = S_PAYLOAD;
                        end else begin
                            rep_d = rep_q + 8'd1;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_tvalid && o_tready && i_tlast) begin
                    state_d = (gap_len_q != 16'd0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (o_tready) begin
                    if (gap_cnt_q == gap_len_q - 16'd1) begin
                        gap_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_c = 1'b0;
        ready_c = 1'b0;
        last_c  = 1'b0;
        user_c  = 1'b0;
        data_c  = '0;
        unique case (state_q)
            S_PREAMBLE: begin
                valid_c = 1'b1;
                user_c  = 1'b1;
                data_c  = pattern_q[idx_q];
            end
            S_PAYLOAD: begin
                valid_c = i_tvalid;
                ready_c = o_tready;
                last_c  = i_tlast;
                data_c  = i_tdata;
            end
            S_GAP:   valid_c = 1'b1;
            default: valid_c = 1'b0;
        endcase
    end

    // Handshake outputs are forced low for the whole reset pulse.
    assign o_tvalid = valid_c & ~reset;
    assign i_tready = ready_c & ~reset;
    assign o_tlast  = last_c & ~reset;
    assign o_tuser  = user_c & ~reset;
    assign o_tdata  = data_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rep_q      <= '0;
            gap_cnt_q  <= '0;
            pattern_q  <= '{default: '0};
            ctrl_en_q  <= 1'b1;
            ctrl_rep_q <= 8'(NUM_REPEATS);
            ctrl_gap_q <= 16'(GAP_LEN);
            num_rep_q  <= 8'(NUM_REPEATS);
            gap_len_q  <= 16'(GAP_LEN);
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rep_q      <= rep_d;
            gap_cnt_q  <= gap_cnt_d;
            pattern_q  <= pattern_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_rep_q <= ctrl_rep_d;
            ctrl_gap_q <= ctrl_gap_d;
            num_rep_q  <= num_rep_d;
            gap_len_q  <= gap_len_d;
        end
    end

endmodule

// File: tb/tb_short_preamble_inserter.sv
// Randomized bench for short_preamble_inserter: a packet-level model predicts
// every output beat, and stalled outputs are checked for stability.
module tb_short_preamble_inserter;

    localparam int P = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tuser;
    logic        o_tvalid;
    logic        o_tready = 1'b0;

    always #5 clk = ~clk;

    short_preamble_inserter dut (
        .clk      (clk),
        .reset    (reset),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tuser  (o_tuser),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: configuration and pattern as the bench believes them to be.
    logic [31:0] m_pat [P];
    bit          m_en  = 1'b1;
    int          m_rep = 10;
    int          m_gap = 0;

    logic [33:0] exp_q [$];   // {user, last, data}
    logic [32:0] in_q  [$];   // {last, data}

    int          vprob = 100;
    int          rprob = 100;
    bit          in_hs = 1'b0;
    bit          prev_stall = 1'b0;
    logic [33:0] held = '0;
    bit          last_hs = 1'b0;
    bit          last_user = 1'b0;
    int          pre_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [32:0] tmp;
        @(posedge clk);
        #1;
        set_stb = 1'b0;
        if (in_hs) begin
            tmp      = in_q.pop_front();
            i_tvalid = 1'b0;
            in_hs    = 1'b0;
        end
        if (in_q.size() > 0) begin
            if (!i_tvalid && $urandom_range(99) < vprob) begin
                i_tvalid = 1'b1;
                {i_tlast, i_tdata} = in_q[0];
            end
        end else begin
            i_tvalid = 1'b0;
        end
        o_tready = ($urandom_range(99) < rprob);
        #1;
        last_hs = 1'b0;
        if (reset) begin
            check_eq("rst_o_tvalid", o_tvalid, 0);
            check_eq("rst_i_tready", i_tready, 0);
            prev_stall = 1'b0;
            in_hs      = 1'b0;
            return;
        end
        in_hs = i_tvalid && i_tready;
        if (prev_stall) begin
            check_eq("hold_valid", o_tvalid, 1);
            check_eq("hold_beat", {o_tuser, o_tlast, o_tdata}, held);
        end
        if (o_tvalid && o_tready) begin
            last_hs   = 1'b1;
            last_user = o_tuser;
            if (o_tuser) pre_cnt++;
            check_eq("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check_eq("out_beat", {o_tuser, o_tlast, o_tdata}, exp_q.pop_front());
            end
        end
        prev_stall = o_tvalid && !o_tready;
        held       = {o_tuser, o_tlast, o_tdata};
    endtask

    task automatic write_sr(input int addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = 8'(addr);
        set_data = data;
        if (addr == 127) begin
            m_en  = data[0];
            m_rep = int'(data[15:8]);
            m_gap = int'(data[31:16]);
        end else if (addr >= 128 && addr < 128 + P) begin
            m_pat[addr-128] = data;
        end
        step();
    endtask

    task automatic enqueue_packet(input int len);
        logic [31:0] d;
        if (m_en && m_rep > 0) begin
            for (int r = 0; r < m_rep; r++) begin
                for (int k = 0; k < P; k++) exp_q.push_back({2'b10, m_pat[k]});
            end
        end
        for (int i = 0; i < len; i++) begin
            d = $urandom;
            in_q.push_back({i == len - 1, d});
            exp_q.push_back({1'b0, i == len - 1, d});
        end
        for (int g = 0; g < m_gap; g++) exp_q.push_back(34'h0);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0) && c < budget) begin
            step();
            c++;
        end
        check_eq("drain_done", exp_q.size() + in_q.size(), 0);
    endtask

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            check_eq("idle_o_tvalid", o_tvalid, 0);
            check_eq("idle_i_tready", i_tready, 0);
        end
    endtask

    initial begin
        int c;
        int reps [4] = '{0, 1, 3, 5};
        for (int k = 0; k < P; k++) m_pat[k] = '0;

        step();
        check_eq("rst_o_tuser", o_tuser, 0);
        check_eq("rst_o_tlast", o_tlast, 0);
        step();
        reset = 1'b0;
        check_idle(3);

        // Default config, ramp pattern, always-ready sink.
        for (int k = 0; k < P; k++) write_sr(128 + k, 32'h0001_0000 * k + k);
        pre_cnt = 0;
        enqueue_packet(4);
        drain(1000);
        check_eq("pre_len_default", pre_cnt, 160);

        // Two repeats with a three-sample zero gap.
        write_sr(127, 32'h0003_0201);
        pre_cnt = 0;
        enqueue_packet(2);
        drain(1000);
        check_eq("pre_len_rep2", pre_cnt, 32);
        check_idle(3);

        // Preamble disabled: pure pass-through.
        write_sr(127, 32'h0000_0A00);
        pre_cnt = 0;
        enqueue_packet(5);
        drain(1000);
        check_eq("pre_len_disabled", pre_cnt, 0);

        // Single-sample packet still gets the full preamble.
        write_sr(127, 32'h0001_0101);
        enqueue_packet(1);
        drain(1000);

        // Randomized handshakes and configurations.
        vprob = 70;
        rprob = 50;
        for (int blk = 0; blk < 5; blk++) begin
            write_sr(127, {16'($urandom_range(0, 3)), 8'(reps[$urandom_range(0, 3)]),
                           7'd0, 1'($urandom_range(0, 3) != 0)});
            if (blk % 2 == 1) begin
                for (int k = 0; k < P; k++) write_sr(128 + k, $urandom);
            end
            for (int p = 0; p < 20; p++) enqueue_packet($urandom_range(1, 6));
            drain(20000);
        end

        // Control write during payload affects only the following packet.
        vprob = 100;
        rprob = 100;
        write_sr(127, 32'h0000_0A01);
        pre_cnt = 0;
        enqueue_packet(3);
        c = 0;
        while (!(last_hs && !last_user) && c < 1000) begin
            step();
            c++;
        end
        check_eq("reached_payload", last_hs && !last_user, 1);
        write_sr(127, 32'h0000_0301);
        enqueue_packet(2);
        drain(1000);
        check_eq("pre_len_mid_write", pre_cnt, 160 + 48);

        // Reset in the middle of a preamble.
        write_sr(127, 32'h0000_0A01);
        pre_cnt = 0;
        enqueue_packet(4);
        c = 0;
        while (pre_cnt < 50 && c < 1000) begin
            step();
            c++;
        end
        check_eq("reached_pre50", pre_cnt, 50);
        reset    = 1'b1;
        i_tvalid = 1'b0;
        in_hs    = 1'b0;
        in_q.delete();
        exp_q.delete();
        for (int k = 0; k < P; k++) m_pat[k] = '0;
        m_en  = 1'b1;
        m_rep = 10;
        m_gap = 0;
        step();
        step();
        reset = 1'b0;
        check_idle(4);
        pre_cnt = 0;
        enqueue_packet(2);
        drain(1000);
        check_eq("pre_len_after_reset", pre_cnt, 160);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/short_preamble_inserter.md
SHORT_PREAMBLE_INSERTER -- requirements
Module: short_preamble_inserter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning sample width in bits ({I[15:0],Q[15:0]} for 32).
REQ-002 The block SHALL have parameter PERIOD, default 16, meaning samples per preamble repetition (power of 2, 2..64).
REQ-003 The block SHALL have parameter NUM_REPEATS, default 10, meaning reset value of the repeat-count register.
REQ-004 The block SHALL have parameter GAP_LEN, default 0, meaning reset value of the inter-packet zero-gap register.
REQ-005 The block SHALL have parameter SR_PATTERN_BASE, default 128, meaning settings address of pattern entry 0 (entries at BASE..BASE+PERIOD-1).
REQ-006 The block SHALL have parameter SR_CTRL, default 127, meaning settings address of the control register.
REQ-007 Ports SHALL be: clk in 1 clock; reset in 1 (synchronous, active-high); set_stb in 1 settings strobe; set_addr in 8 settings address; set_data in 32 settings data.
REQ-008 Ports SHALL be: i_tdata in WIDTH payload sample; i_tlast in 1 end of packet; i_tvalid in 1; i_tready out 1.
REQ-009 Ports SHALL be: o_tdata out WIDTH; o_tlast out 1 last payload sample; o_tuser out 1 high on preamble samples; o_tvalid out 1; o_tready in 1.

Function
REQ-010 A write with set_addr=SR_PATTERN_BASE+k SHALL load set_data[WIDTH-1:0] into pattern[k], effective the next cycle, including mid-preamble.
REQ-011 SR_CTRL SHALL hold bit0 enable (reset 1), bits[15:8] num_repeats (reset NUM_REPEATS), bits[31:16] gap_len (reset GAP_LEN).
REQ-012 enable, num_repeats and gap_len SHALL be latched only on the IDLE exit transition; mid-packet SR_CTRL writes affect the next packet only.
REQ-013 States SHALL be S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP.
REQ-014 S_IDLE: o_tvalid=0, i_tready=0; on i_tvalid=1 go to S_PREAMBLE if latched enable=1 and num_repeats>0, else to S_PAYLOAD; no input sample consumed.
REQ-015 S_PREAMBLE: o_tvalid=1, o_tuser=1, o_tlast=0, o_tdata=pattern[idx], i_tready=0; idx and rep advance only on o_tvalid&o_tready.
REQ-016 idx SHALL wrap PERIOD-1->0 incrementing rep; on the handshake with idx=PERIOD-1 and rep=num_repeats-1 go to S_PAYLOAD.
REQ-017 Preamble length SHALL be exactly num_repeats*PERIOD samples (default 160).
REQ-018 S_PAYLOAD: o_tdata=i_tdata, o_tvalid=i_tvalid, i_tready=o_tready, o_tlast=i_tlast, o_tuser=0 (combinational pass-through, zero latency).
REQ-019 On payload handshake with i_tlast=1 go to S_GAP if latched gap_len>0, else S_IDLE.
REQ-020 S_GAP: o_tvalid=1, o_tdata=0, o_tuser=0, o_tlast=0, i_tready=0; exactly gap_len handshakes then S_IDLE.
REQ-021 o_tdata/o_tuser/o_tlast SHALL remain stable while o_tvalid=1 and o_tready=0 (AXI hold), including across pattern writes to any entry other than the one presented.
REQ-022 Minimum packet overhead SHALL be one idle cycle between packets (S_IDLE dwell of 1 cycle when i_tvalid already high).
REQ-023 A single-sample packet (i_tlast on first payload sample) SHALL be fully preamble-prefixed and terminated like any other.
REQ-024 idx and rep counters SHALL be sized for PERIOD-1 and 255 respectively with no overflow.

Reset
REQ-025 During reset: state=S_IDLE, idx=0, rep=0, gap counter=0, o_tvalid=0, i_tready=0, o_tlast=0, o_tuser=0, pattern[*]=0, SR_CTRL to REQ-011 reset values.
REQ-026 Reset asserted mid-packet SHALL abort immediately; next cycle after deassertion the block SHALL be in S_IDLE with no partial preamble or payload emitted.

Verification
REQ-027 Pattern k=0..15 loaded with 0x00010000*k+k, 4-sample packet, o_tready=1 -> 160 tuser samples cycling pattern 0..15 ten times, then 4 payload samples, tlast on the 4th.
REQ-028 SR_CTRL=0x00030201 (repeats=2, gap=3), 2-sample packet -> 32 preamble, 2 payload, 3 zero samples, then idle.
REQ-029 SR_CTRL enable=0, 5-sample packet -> 5 output samples identical to input, tuser=0, no preamble.
REQ-030 Random o_tready (50%) and i_tvalid (70%) over 100 packets -> output sequence bit-exact against model, no drop/duplicate, AXI hold respected.
REQ-031 SR_CTRL write repeats=3 during payload of packet N -> packet N unaffected, packet N+1 gets 48 preamble samples.
REQ-032 Reset pulsed at preamble sample 50 -> o_tvalid=0 during and after reset until new i_tvalid; next packet gets full 160-sample preamble.
